// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmitter and receiver blocks.
//   uart_state_t : frame FSM state encoding
//   PAR_*        : values accepted by the PARITY parameter
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_baud_timer.sv
// uart_baud_timer
// Down-counter that times one bit (or one multi-bit span) of a UART frame.
//   clk        : system clock, rising edge
//   srst       : synchronous reset, active-high (counter -> 0)
//   restart    : load load_value this cycle
//   load_value : span length minus one
//   bit_end    : high in the last cycle of the span (count == 0)
//   bit_last   : high one cycle before bit_end (count == 1)
module uart_baud_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             restart,
  input  logic [WIDTH-1:0] load_value,
  output logic             bit_end,
  output logic             bit_last
);

  logic [WIDTH-1:0] count_reg;

  // Parks at zero once expired; every span starts from an explicit restart,
  // so no error can carry from one bit into the next.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (restart) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign bit_end  = (count_reg == '0);
  assign bit_last = (count_reg == WIDTH'(1));

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity,
// one or two stop bits.
//   CLK_i   : system clock, rising edge
//   reset_i : synchronous reset, active-high
//   data_i  : byte to send, sampled on the valid/ready handshake
//   valid_i : data_i is valid
//   ready_o : idle, a byte can be accepted
//   Tx_o    : serial line, idle high, registered
//   busy_o  : frame in progress
//   done_o  : one-cycle pulse in the last cycle of the final stop bit
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLK_i,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       Tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int TIMER_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] BIT_LOAD  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] STOP_LOAD = TIMER_W'(STOP_BITS * CLKS_PER_BIT - 1);

  uart_state_t  state_reg;
  logic [7:0]   shift_reg;
  logic [2:0]   bit_idx_reg;
  logic         parity_reg;
  logic         tx_reg;
  logic         done_reg;

  logic               timer_restart;
  logic [TIMER_W-1:0] timer_load;
  logic               bit_end;
  logic               bit_last;

  // Restart the timer on every state/bit change; the stop span is timed as a
  // single STOP_BITS-long interval.
  always_comb begin
    timer_restart = 1'b0;
    timer_load    = BIT_LOAD;
    case (state_reg)
      UART_IDLE:  timer_restart = valid_i;
      UART_START: timer_restart = bit_end;
      UART_DATA: begin
        timer_restart = bit_end;
        if (bit_idx_reg == 3'd7 && PARITY == PAR_NONE) begin
          timer_load = STOP_LOAD;
        end
      end
      UART_PARITY: begin
        timer_restart = bit_end;
        timer_load    = STOP_LOAD;
      end
      default: timer_restart = 1'b0;
    endcase
  end

  uart_baud_timer #(
    .WIDTH(TIMER_W)
  ) baud_timer (
    .clk       (CLK_i),
    .srst      (reset_i),
    .restart   (timer_restart),
    .load_value(timer_load),
    .bit_end   (bit_end),
    .bit_last  (bit_last)
  );

  // Tx_o is registered and always loaded with the level of the bit being
  // entered, so the line changes on the same edge as the state.
  always_ff @(posedge CLK_i) begin
    if (reset_i) begin
      state_reg   <= UART_IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        UART_IDLE: begin
          if (valid_i) begin
            shift_reg   <= data_i;
            bit_idx_reg <= '0;
            parity_reg  <= (PARITY == PAR_ODD) ? ~^data_i : ^data_i;
            tx_reg      <= 1'b0;
            state_reg   <= UART_START;
          end
        end
        UART_START: begin
          if (bit_end) begin
            tx_reg    <= shift_reg[0];
            state_reg <= UART_DATA;
          end
        end
        UART_DATA: begin
          if (bit_end) begin
            if (bit_idx_reg == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                tx_reg    <= parity_reg;
                state_reg <= UART_PARITY;
              end else begin
                tx_reg    <= 1'b1;
                state_reg <= UART_STOP;
              end
            end else begin
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end
        end
        UART_PARITY: begin
          if (bit_end) begin
            tx_reg    <= 1'b1;
            state_reg <= UART_STOP;
          end
        end
        UART_STOP: begin
          // Registered pulse: set one cycle early so it lands on the last cycle.
          if (bit_last) begin
            done_reg <= 1'b1;
          end
          if (bit_end) begin
            state_reg <= UART_IDLE;
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= UART_IDLE;
        end
      endcase
    end
  end

  assign ready_o = (state_reg == UART_IDLE);
  assign busy_o  = ~ready_o;
  assign Tx_o    = tx_reg;
  assign done_o  = done_reg;

endmodule
